// File: rtl/tc_program_fetch_ctrl_if.sv
// tc_program_fetch_ctrl_if: program-memory port, decoder handshake, redirect and data-read signals
// of the fetch controller; master is the controller side, slave the surrounding system.
interface tc_program_fetch_ctrl_if #(parameter int BIT_WIDTH = 16);
  logic [15:0]          mem_addr;
  logic [BIT_WIDTH-1:0] mem_word0, mem_word1, mem_word2, mem_word3;
  logic                 instr_valid, instr_ready;
  logic [BIT_WIDTH-1:0] instr_word0, instr_word1, instr_word2, instr_word3;
  logic [2:0]           instr_len;
  logic [15:0]          instr_pc;
  logic                 jump_valid;
  logic [15:0]          jump_target;
  logic                 halt;
  logic                 rd_req;
  logic [15:0]          rd_addr;
  logic                 rd_ack;
  logic [BIT_WIDTH-1:0] rd_data;
  modport master (
    output mem_addr, instr_valid, instr_word0, instr_word1, instr_word2, instr_word3,
           instr_len, instr_pc, rd_ack, rd_data,
    input  mem_word0, mem_word1, mem_word2, mem_word3, instr_ready, jump_valid,
           jump_target, halt, rd_req, rd_addr
  );
  modport slave (
    input  mem_addr, instr_valid, instr_word0, instr_word1, instr_word2, instr_word3,
           instr_len, instr_pc, rd_ack, rd_data,
    output mem_word0, mem_word1, mem_word2, mem_word3, instr_ready, jump_valid,
           jump_target, halt, rd_req, rd_addr
  );
endinterface

// File: rtl/tc_program_fetch_ctrl.sv
// tc_program_fetch_ctrl: PC owner and instruction fetcher sharing one program-memory address
// port with a data-read requester; a pending read is forced through after MAX_WAIT lost cycles.
module tc_program_fetch_ctrl #(
  parameter int          BIT_WIDTH    = 16,
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          MAX_WAIT     = 4
) (
  input logic clk,
  input logic rst,
  tc_program_fetch_ctrl_if.master bus
);
  logic [15:0]                pc_q, pc_d, ipc_q, ipc_d;
  logic                       valid_q, valid_d, ack_q, ack_d;
  logic [2:0]                 len_q, len_d, fetch_len;
  logic [3:0]                 wait_q, wait_d;
  logic [BIT_WIDTH-1:0]       data_q, data_d;
  logic [3:0][BIT_WIDTH-1:0]  word_q, word_d, mem_w;
  logic                       want_fetch, rd_elig, grant_rd, grant_fetch;
  assign mem_w = {bus.mem_word3, bus.mem_word2, bus.mem_word1, bus.mem_word0};
  always_comb begin
    want_fetch  = (!valid_q || bus.instr_ready) && !bus.halt && !bus.jump_valid;
    rd_elig     = bus.rd_req && !ack_q;
    grant_rd    = rd_elig && (!want_fetch || wait_q == 4'(MAX_WAIT));
    grant_fetch = want_fetch && !grant_rd;
    fetch_len   = {1'b0, bus.mem_word0[BIT_WIDTH-1 -: 2]} + 3'd1;
    // a read that is losing cannot already be at MAX_WAIT, so the increment never overshoots
    wait_d  = (grant_rd || !bus.rd_req) ? 4'd0 : rd_elig ? wait_q + 4'd1 : wait_q;
    ack_d   = grant_rd;
    data_d  = grant_rd ? bus.mem_word0 : data_q;
    pc_d    = bus.jump_valid ? bus.jump_target : grant_fetch ? pc_q + {13'd0, fetch_len} : pc_q;
    valid_d = grant_fetch || (valid_q && !bus.instr_ready && !bus.jump_valid);
    word_d  = grant_fetch ? mem_w : word_q;
    len_d   = grant_fetch ? fetch_len : len_q;
    ipc_d   = grant_fetch ? pc_q : ipc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_VECTOR;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      len_q   <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      word_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      len_q   <= len_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      word_q  <= word_d;
    end
  end
  assign bus.mem_addr    = grant_rd ? bus.rd_addr : pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_word0 = word_q[0];
  assign bus.instr_word1 = word_q[1];
  assign bus.instr_word2 = word_q[2];
  assign bus.instr_word3 = word_q[3];
  assign bus.instr_len   = len_q;
  assign bus.instr_pc    = ipc_q;
  assign bus.rd_ack      = ack_q;
  assign bus.rd_data     = data_q;
endmodule

// File: tb/tb_tc_program_fetch_ctrl.sv
// tb_tc_program_fetch_ctrl: directed scenarios pinned by literal expectations, then randomized
// traffic compared every cycle against a transaction-level model of the fetch controller.
module tb_tc_program_fetch_ctrl;
  localparam int          BW = 16;
  localparam logic [15:0] RV = 16'h0010;
  localparam int          MW = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  tc_program_fetch_ctrl_if #(.BIT_WIDTH(BW)) bus();
  tc_program_fetch_ctrl #(.BIT_WIDTH(BW), .RESET_VECTOR(RV), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );
  logic [BW-1:0] mem [65536];
  assign bus.mem_word0 = mem[bus.mem_addr];
  assign bus.mem_word1 = mem[16'(bus.mem_addr + 16'd1)];
  assign bus.mem_word2 = mem[16'(bus.mem_addr + 16'd2)];
  assign bus.mem_word3 = mem[16'(bus.mem_addr + 16'd3)];
  int checks = 0;
  int errors = 0;
  bit          m_known = 0, m_valid = 0, m_ack = 0;
  logic [15:0] m_pc, m_ipc;
  logic [2:0]  m_len;
  logic [BW-1:0] m_w [4];
  logic [BW-1:0] m_data;
  int          m_lost;
  bit          req_active = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: one instruction record, a PC, a read-in-flight flag and a count of lost read cycles.
  task automatic model_step();
    bit fetch_wanted, read_pending, read_wins;
    logic [15:0] a;
    logic [2:0] l;
    fetch_wanted = (!m_valid || bus.instr_ready) && !bus.halt && !bus.jump_valid;
    read_pending = bus.rd_req && !m_ack;
    read_wins    = read_pending && (!fetch_wanted || m_lost >= MW);
    if (m_known) chk("mem_addr", bus.mem_addr, read_wins ? bus.rd_addr : m_pc);
    if (!rst) begin
      m_known = 1; m_pc = RV; m_valid = 0; m_ack = 0; m_data = '0; m_lost = 0;
      m_ipc = '0; m_len = '0;
      for (int k = 0; k < 4; k++) m_w[k] = '0;
      return;
    end
    if (!m_known) return;
    a = m_pc;
    if (read_wins) m_data = mem[bus.rd_addr];
    m_ack = read_wins;
    if (!bus.rd_req || read_wins) m_lost = 0;
    else if (read_pending) m_lost = (m_lost < MW) ? m_lost + 1 : MW;
    if (bus.jump_valid) begin
      m_pc = bus.jump_target;
      m_valid = 0;
    end else if (fetch_wanted && !read_wins) begin
      l = 3'(mem[a][BW-1 -: 2]) + 3'd1;
      for (int k = 0; k < 4; k++) m_w[k] = mem[16'(a + 16'(k))];
      m_len = l; m_ipc = a; m_pc = a + 16'(l); m_valid = 1;
    end else if (bus.instr_ready) m_valid = 0;
  endtask
  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (m_known) begin
      chk("instr_valid", bus.instr_valid, m_valid);
      chk("instr_len", bus.instr_len, m_len);
      chk("instr_pc", bus.instr_pc, m_ipc);
      chk("instr_word0", bus.instr_word0, m_w[0]);
      chk("instr_word1", bus.instr_word1, m_w[1]);
      chk("instr_word2", bus.instr_word2, m_w[2]);
      chk("instr_word3", bus.instr_word3, m_w[3]);
      chk("rd_ack", bus.rd_ack, m_ack);
      chk("rd_data", bus.rd_data, m_data);
    end
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = BW'($urandom);
    mem[16'h0010] = 16'h4000;
    mem[16'h0000] = 16'h0000;
    mem[16'h0001] = 16'hC000;
    mem[16'h0005] = 16'h8000;
    mem[16'hFFFE] = 16'h8000;
    mem[16'h0040] = 16'hBEEF;
    mem[16'h0041] = 16'h1234;
    bus.instr_ready = 1; bus.jump_valid = 0; bus.jump_target = '0; bus.halt = 0;
    bus.rd_req = 0; bus.rd_addr = '0;
    // reset and first fetch from the reset vector
    rst = 0;
    cycle();
    cycle();
    chk("rst_mem_addr", bus.mem_addr, 16'h0010);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_rd_ack", bus.rd_ack, 0);
    rst = 1;
    cycle();
    chk("first_valid", bus.instr_valid, 1);
    chk("first_pc", bus.instr_pc, 16'h0010);
    chk("first_len", bus.instr_len, 2);
    chk("first_next_addr", bus.mem_addr, 16'h0012);
    // lengths 1,4,3 back to back
    bus.jump_valid = 1; bus.jump_target = 16'h0000;
    cycle();
    chk("jump0_flush", bus.instr_valid, 0);
    bus.jump_valid = 0;
    cycle();
    chk("seq_pc0", bus.instr_pc, 16'h0000);
    chk("seq_len1", bus.instr_len, 1);
    cycle();
    chk("seq_pc1", bus.instr_pc, 16'h0001);
    chk("seq_len4", bus.instr_len, 4);
    cycle();
    chk("seq_pc5", bus.instr_pc, 16'h0005);
    chk("seq_len3", bus.instr_len, 3);
    chk("seq_next_pc", bus.mem_addr, 16'h0008);
    // PC wrap
    bus.jump_valid = 1; bus.jump_target = 16'hFFFE;
    cycle();
    bus.jump_valid = 0;
    cycle();
    chk("wrap_pc", bus.instr_pc, 16'hFFFE);
    chk("wrap_next", bus.mem_addr, 16'h0001);
    // stall then jump during stall
    bus.instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_pc", bus.instr_pc, 16'hFFFE);
      chk("stall_len", bus.instr_len, 3);
      chk("stall_valid", bus.instr_valid, 1);
    end
    bus.jump_valid = 1; bus.jump_target = 16'h0100;
    cycle();
    chk("jstall_flush", bus.instr_valid, 0);
    chk("jstall_addr", bus.mem_addr, 16'h0100);
    bus.jump_valid = 0;
    cycle();
    chk("jtarget_valid", bus.instr_valid, 1);
    chk("jtarget_pc", bus.instr_pc, 16'h0100);
    // read starvation guard
    bus.instr_ready = 1; bus.rd_req = 1; bus.rd_addr = 16'h0040;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("starve_ack", bus.rd_ack, 0);
      chk("starve_valid", bus.instr_valid, 1);
    end
    chk("forced_addr", bus.mem_addr, 16'h0040);
    cycle();
    chk("forced_ack", bus.rd_ack, 1);
    chk("forced_data", bus.rd_data, 16'hBEEF);
    chk("forced_drain", bus.instr_valid, 0);
    chk("no_regrant", bus.mem_addr == 16'h0040, 0);
    // read during halt, then reset in the ack cycle
    bus.rd_req = 0; bus.instr_ready = 0;
    cycle();
    bus.halt = 1; bus.rd_req = 1; bus.rd_addr = 16'h0041;
    #1;
    chk("halt_grant_addr", bus.mem_addr, 16'h0041);
    cycle();
    chk("halt_ack", bus.rd_ack, 1);
    chk("halt_data", bus.rd_data, 16'h1234);
    chk("halt_valid", bus.instr_valid, 1);
    rst = 0; bus.rd_req = 0;
    cycle();
    chk("rst2_valid", bus.instr_valid, 0);
    chk("rst2_ack", bus.rd_ack, 0);
    chk("rst2_data", bus.rd_data, 0);
    chk("rst2_len", bus.instr_len, 0);
    chk("rst2_pc", bus.instr_pc, 0);
    chk("rst2_word0", bus.instr_word0, 0);
    chk("rst2_addr", bus.mem_addr, RV);
    rst = 1; bus.halt = 0;
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(99) != 0);
      bus.instr_ready = ($urandom_range(3) != 0);
      bus.halt = ($urandom_range(7) == 0);
      bus.jump_valid = ($urandom_range(15) == 0);
      bus.jump_target = 16'($urandom);
      if (req_active && m_ack) req_active = 0;
      if (!rst) req_active = 0;
      if (!req_active && $urandom_range(3) == 0) begin
        req_active = 1;
        bus.rd_addr = 16'($urandom);
      end
      bus.rd_req = req_active;
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tc_program_fetch_ctrl.md
Name: tc_program_fetch_ctrl

Overview:
- Fetch sequencer and port arbiter in front of a TC program-word memory. The memory has one address input, reads combinationally, and returns 4 consecutive words.
- Owns the program counter and decodes instruction length (1-4 words) from the first word.
- Presents registered instructions to the decoder with a valid/ready handshake.
- Shares the single memory address port with a constant/data read requester, using a starvation guard.

Parameters:
- BIT_WIDTH, 16, width of one program word (8/16/32/64).
- RESET_VECTOR, 16'h0000, PC value after reset.
- MAX_WAIT, 4, consecutive cycles a pending data read may lose to fetch before it is forced through (1..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset: rst=0 at a rising edge resets the block.
- mem_addr  out  16  address to program memory; combinational mux of PC / rd_addr.
- mem_word0..mem_word3  in  BIT_WIDTH each  memory words at mem_addr+0..+3.
- instr_valid  out  1  instruction register holds a valid instruction.
- instr_ready  in  1  decoder accepts instruction this cycle.
- instr_word0..instr_word3  out  BIT_WIDTH each  latched instruction words.
- instr_len  out  3  instruction length in words, 1..4.
- instr_pc  out  16  address of instr_word0.
- jump_valid  in  1  redirect request.
- jump_target  in  16  new PC.
- halt  in  1  suppress instruction fetch.
- rd_req  in  1  data read request; held until rd_ack.
- rd_addr  in  16  data read address.
- rd_ack  out  1  one-cycle pulse: rd_data valid.
- rd_data  out  BIT_WIDTH  word read at rd_addr.

Behaviour:
- Reset (rst=0 at a clock edge):
  - pc=RESET_VECTOR.
  - instr_valid=0; instr_word0..3=0; instr_len=0; instr_pc=0.
  - rd_ack=0; rd_data=0; wait_cnt=0.
  - mem_addr then equals RESET_VECTOR.
  - Reset overrides all inputs, including an in-flight handshake.
- Definitions:
  - slot_free = !instr_valid || instr_ready.
  - want_fetch = slot_free && !halt && !jump_valid.
  - rd_elig = rd_req && !rd_ack (no grant in the cycle rd_ack is high).
- Arbitration, evaluated each cycle:
  - grant_rd = rd_elig && (!want_fetch || wait_cnt == MAX_WAIT).
  - grant_fetch = want_fetch && !grant_rd.
  - mem_addr = grant_rd ? rd_addr : pc.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) when rd_elig && !grant_rd.
  - Clears on grant_rd or when rd_req=0.
- Data read:
  - On grant_rd, rd_data <= mem_word0 and rd_ack <= 1 at the next edge (latency 1).
  - Otherwise rd_ack <= 0; rd_data holds its value.
- Fetch (grant_fetch):
  - instr_word0..3 <= mem_word0..3; instr_pc <= pc.
  - instr_len <= mem_word0[BIT_WIDTH-1:BIT_WIDTH-2] + 1.
  - pc <= pc + that length, mod 2^16 (wraps FFFF->0000).
  - instr_valid <= 1.
  - Words past the instruction length are latched unchanged; the decoder ignores them.
- Consume without refill (instr_valid && instr_ready && !grant_fetch): instr_valid <= 0; other instruction fields hold.
- Stall (instr_valid && !instr_ready): all instr_* outputs hold stable.
- Jump (jump_valid=1) has priority over fetch:
  - pc <= jump_target; instr_valid <= 0 (flush).
  - An instr_ready in the same cycle is still a completed handshake.
  - First fetch from the target happens in the following cycle at the earliest.
  - The memory port is free during the jump cycle, so a pending rd_req is granted then.
- halt=1: no fetch and pc holds. The current instruction may still be consumed. Data reads are served every eligible cycle.
- Throughput:
  - One instruction per cycle when instr_ready=1 and there are no reads.
  - A data read steals exactly one fetch cycle.

Test Plan:
- Reset with rst=0 for 2 cycles and RESET_VECTOR=0x0010, then rst=1 with memory word0=0x4000 (len 2) -> mem_addr=0x0010 during reset. First edge after release: instr_valid=1, instr_pc=0x0010, instr_len=2. Next mem_addr=0x0012.
- Lengths 1,4,3 in sequence with instr_ready=1 -> instr_pc 0x0000, 0x0001, 0x0005; pc=0x0008; one instruction per cycle. Start pc=0xFFFE with a len-3 word -> next pc=0x0001.
- Hold instr_ready=0 for 3 cycles while valid -> instr_word0..3, instr_pc, instr_len stable. mem_addr switches to rd_addr only if rd_req is asserted.
- jump_valid with target 0x0100 while instr_valid=1, instr_ready=0 -> next cycle instr_valid=0 and pc=0x0100. Following cycle: instr_pc=0x0100, valid=1.
- rd_req at rd_addr=0x0040 with instr_ready=1 continuously and MAX_WAIT=4 -> fetch wins 4 cycles; 5th cycle mem_addr=0x0040; next cycle rd_ack=1 and rd_data=mem[0x0040]. rd_req held during the ack cycle -> no regrant in that cycle.
- rd_req during halt=1 -> grant the same cycle, rd_ack the next. Pulling rst=0 in the rd_ack/instr_valid cycle -> all outputs zero at the next edge.
